// File: rtl/arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arb_pkg: shared types and constants for the 4-way RR arbiter.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package arb_pkg;

  localparam int NREQ         = 4;
  localparam int DEF_MAX_HOLD = 15;

  // 2'd3 is unused; the FSM decodes it as IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick_4: rotating-priority select, first set bit from ptr up.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      pick,
  output logic            any
);

  logic       w_found;
  logic [1:0] w_idx;

  always_comb begin
    pick    = ptr;
    w_found = 1'b0;
    w_idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        pick    = w_idx;
        w_found = 1'b1;
      end
    end
    any = |req;
  end

endmodule : rr_pick_4
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter_4: round-robin arbiter with hold limit and grant count.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int HOLD_W   = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  gnt,
  output logic [1:0]       grant_idx,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] grant_cnt,
  output logic             cnt_ov
);

  state_t             r_state, w_state_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
  logic [1:0]         r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]    w_gnt_nxt;
  logic [1:0]         w_idx_nxt;
  logic               w_busy_nxt, w_to_nxt, w_ov_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [1:0]         w_pick;
  logic               w_any;
  logic               w_done_cur, w_hold_exp, w_release;

  rr_pick_4 u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  // Only the current grantee's done/req can end a grant.
  assign w_done_cur = done[grant_idx];
  assign w_hold_exp = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign w_release  = w_done_cur || !req[grant_idx] || w_hold_exp;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = gnt;
    w_idx_nxt   = grant_idx;
    w_busy_nxt  = busy;
    w_to_nxt    = 1'b0;
    w_cnt_nxt   = grant_cnt;
    w_ov_nxt    = 1'b0;
    case (r_state)
      GRANT: begin
        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        if (w_release) begin
          w_state_nxt = GAP;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_hold_nxt  = '0;
          w_ptr_nxt   = grant_idx + 2'd1;
          w_to_nxt    = w_hold_exp && !w_done_cur;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        if (w_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = NREQ'(1) << w_pick;
          w_idx_nxt   = w_pick;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = '0;
          w_cnt_nxt   = grant_cnt + CNT_W'(1);
          w_ov_nxt    = &grant_cnt;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_ptr      <= '0;
      gnt        <= '0;
      grant_idx  <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      grant_cnt  <= '0;
      cnt_ov     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_ptr      <= w_ptr_nxt;
      gnt        <= w_gnt_nxt;
      grant_idx  <= w_idx_nxt;
      busy       <= w_busy_nxt;
      timeout    <= w_to_nxt;
      grant_cnt  <= w_cnt_nxt;
      cnt_ov     <= w_ov_nxt;
    end
  end

endmodule : rr_arbiter_4
`default_nettype wire
